// File: rtl/fifo_cascade_sequencer.sv
// Cascade FIFO sequencer: fills N_STAGES FIFOs stage by stage from a valid/ready
// stream, shifting earlier blocks down the demux chain, then drains the last FIFO.
module fifo_cascade_sequencer #(
    parameter int unsigned N_STAGES  = 4,
    parameter int unsigned BLOCK_LEN = 88,
    parameter int unsigned CNT_W     = 7,
    parameter int unsigned SEL_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic                  i_out_ready,
    output logic                  o_out_valid,
    output logic [N_STAGES-1:0]   o_write_en,
    output logic [N_STAGES-1:0]   o_read_en,
    output logic [N_STAGES-2:0]   o_sel_demux,
    output logic [SEL_W-1:0]      o_stage_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SEL_W-1:0] r_stage_idx;
    logic [SEL_W-1:0] w_stage_next;
    logic             r_done;
    logic             w_last_beat;

    assign w_last_beat = (r_cnt == LAST_BEAT);
    assign o_stage_idx = r_stage_idx;
    assign o_done      = r_done;
    assign o_busy      = (r_state != ST_IDLE);

    // State, beat counter, stage index and done pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_stage_idx <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_stage_idx <= w_stage_next;
            r_done      <= (w_state_next == ST_DONE);
        end
    end

    // Next-state logic and handshake/strobe decode; abort wins over every transition
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stage_next = r_stage_idx;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_write_en   = '0;
        o_read_en    = '0;
        o_sel_demux  = '0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_next = ST_FILL;
                    w_cnt_next   = '0;
                    w_stage_next = '0;
                end
            end

            ST_FILL: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_stage_next = '0;
                end else begin
                    o_in_ready = 1'b1;
                    if (i_in_valid) begin
                        // Stage s writes FIFOs 0..s and shifts FIFO k into k+1 for k<s
                        for (int unsigned k = 0; k < N_STAGES; k++) begin
                            if (SEL_W'(k) <= r_stage_idx) o_write_en[k] = 1'b1;
                            if (SEL_W'(k) <  r_stage_idx) o_read_en[k]  = 1'b1;
                        end
                        for (int unsigned k = 0; k < N_STAGES - 1; k++) begin
                            if (SEL_W'(k) < r_stage_idx) o_sel_demux[k] = 1'b1;
                        end
                        if (w_last_beat) begin
                            w_cnt_next = '0;
                            if (r_stage_idx != LAST_STAGE) begin
                                w_stage_next = r_stage_idx + SEL_W'(1);
                            end else begin
                                w_state_next = ST_DRAIN;
                            end
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_stage_next = '0;
                end else begin
                    o_out_valid = 1'b1;
                    if (i_out_ready) begin
                        o_read_en[N_STAGES-1] = 1'b1;
                        if (w_last_beat) begin
                            w_state_next = ST_DONE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_stage_next = '0;
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_stage_next = '0;
            end
        endcase
    end

endmodule

// File: doc/fifo_cascade_sequencer.md
Name: fifo_cascade_sequencer

Overview:
Sequences a cascade of N_STAGES sample FIFOs joined by demuxes. Each FIFO holds one block of BLOCK_LEN samples. The block accepts a stream with a valid/ready handshake and fills the FIFOs stage by stage, shifting earlier blocks down the chain. It then drains the last FIFO through a ready-gated output and pulses done. It sits between the sample source and the FIFO/demux datapath and is the only driver of that datapath's enables and selects.

Parameters:
N_STAGES, 4, number of FIFOs in the cascade (min 2)
BLOCK_LEN, 88, samples per FIFO block (min 2)
CNT_W, 7, beat counter width, must hold BLOCK_LEN-1
SEL_W, 2, stage index width, must hold N_STAGES-1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  synchronous cancel of the current run
in_valid  input  1  source has a sample this cycle
in_ready  output  1  sequencer accepts a sample this cycle
out_ready  input  1  sink can take a drained sample
out_valid  output  1  last FIFO presents a drained sample
write_en  output  N_STAGES  per-FIFO write strobe
read_en  output  N_STAGES  per-FIFO read strobe
sel_demux  output  N_STAGES-1  bit k routes FIFO k output into FIFO k+1
stage_idx  output  SEL_W  current fill stage
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at run completion

Behaviour:
- Registered state: state (IDLE, FILL, DRAIN, DONE), cnt[CNT_W-1:0], stage_idx, done. Reset values: IDLE, 0, 0, 0.
- All other outputs are combinational from registered state and handshake inputs. With state IDLE they are all 0.
- IDLE: in_ready=0, out_valid=0. If start=1, go to FILL with cnt=0 and stage_idx=0.
- FILL:
  - in_ready=1. fire = in_valid & in_ready.
  - On fire, with s = stage_idx: write_en[k]=1 for k<=s; read_en[k]=1 for k<s; sel_demux[k]=1 for k<s.
  - Without fire, all strobes are 0.
  - sel_demux is 0 when there is no fire; no stale selects.
  - cnt increments on fire only. Gaps in in_valid stall without loss.
  - On fire with cnt==BLOCK_LEN-1:
    - cnt returns to 0.
    - If s<N_STAGES-1, stage_idx increments.
    - Otherwise go to DRAIN with stage_idx held at N_STAGES-1.
- DRAIN:
  - in_ready=0, out_valid=1. dfire = out_ready.
  - On dfire, read_en[N_STAGES-1]=1 and cnt increments. All other strobes are 0.
  - On dfire with cnt==BLOCK_LEN-1, go to DONE with cnt=0.
  - out_ready low holds cnt with no read.
- DONE: done=1 for exactly this one cycle, no strobes, then IDLE with stage_idx=0.
- start outside IDLE is ignored; it is not queued.
- abort has priority over all transitions except rst.
  - abort=1 in FILL, DRAIN or DONE: next state is IDLE, cnt=0, stage_idx=0, no done pulse.
  - Strobes in the abort cycle are forced to 0. Neither in_ready nor out_valid is asserted.
  - The datapath FIFOs are not flushed by this block.
- rst mid-run behaves like abort and also clears done.
- Counter never wraps past BLOCK_LEN-1. Its terminal compare is equality only.
- Latency:
  - The start cycle leads to in_ready high on the next cycle.
  - Minimum run is N_STAGES*BLOCK_LEN fill beats, plus BLOCK_LEN drain beats, plus 1 DONE cycle.
  - Defaults: 352+88+1 cycles after FILL entry with continuous valid/ready.
- Invariant: write_en and read_en of the same FIFO are never both high for FIFO N_STAGES-1 during FILL.

Test Plan:
- Basic run, defaults, continuous in_valid/out_ready, start pulse:
  - Expect write_en counts per FIFO of 352/264/176/88.
  - Expect read_en counts of 264/176/88/88.
  - Expect done high exactly once, 441 cycles after FILL entry.
- Random 30% in_valid gaps:
  - Identical strobe counts.
  - No strobe in any cycle with in_valid=0.
  - stage_idx steps 0→1→2→3 exactly at beats 88/176/264.
- out_ready low for 10 cycles mid-DRAIN, at beat 40:
  - cnt holds, read_en[3]=0 and out_valid=1 throughout.
  - Exactly 88 drain reads in total.
- abort at FILL stage 2 beat 50:
  - Next cycle: IDLE, busy=0, stage_idx=0, all strobes 0, no done.
  - A new start then runs a full clean sequence.
- start pulses during FILL and DRAIN: no effect on cnt, stage_idx or completion time.
- rst asserted mid-DRAIN and mid-DONE: all registered outputs return to 0 the next cycle, and done does not pulse.
